// File: rtl/fp_add_subt_unit.sv
// Multi-cycle IEEE-754 adder/subtractor for the CORDIC coprocessor: IDLE -> ALIGN -> ADD -> NORM
// -> ROUND -> DONE, round-to-nearest-even, denormals flushed, saturating overflow/underflow.
module fp_add_subt_unit #(
    parameter int unsigned W  = 32,
    parameter int unsigned EW = 8,
    parameter int unsigned SW = 23
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         beg_add_subt,
    input  logic         ack_add_subt,
    input  logic         add_subt,
    input  logic [W-1:0] Data_X,
    input  logic [W-1:0] Data_Y,
    output logic         ready_add_subt,
    output logic [W-1:0] add_subt_result,
    output logic         overflow_flag,
    output logic         underflow_flag
);

    localparam int unsigned MW = SW + 4;  // hidden bit, fraction, guard, round, sticky
    localparam int unsigned XW = EW + 2;  // signed working exponent
    localparam logic [EW-1:0]        ShiftMax = EW'(SW + 3);
    localparam logic signed [XW-1:0] ExpMax   = XW'((1 << EW) - 1);
    localparam logic signed [XW-1:0] One      = XW'(1);
    localparam logic [W-1:0]         QNan     = {1'b0, {EW{1'b1}}, 1'b1, {(SW-1){1'b0}}};

    typedef enum logic [2:0] {StIdle, StAlign, StAdd, StNorm, StRound, StDone} state_e;

    state_e                state_q;
    logic                  sx_q, sy_q, ix_q, iy_q, nx_q, ny_q;
    logic [EW-1:0]         ex_q, ey_q;
    logic [SW:0]           fx_q, fy_q;
    logic                  sign_q, eff_sub_q, zero_q;
    logic signed [XW-1:0]  exp_q;
    logic [MW-1:0]         ma_q, mb_q;
    logic [MW:0]           sum_q;

    function automatic logic [XW-1:0] lzc(input logic [MW-1:0] v);
        logic [XW-1:0] n;
        n = XW'(MW);
        for (int i = 0; i < MW; i++) begin
            if (v[i]) n = XW'(MW - 1 - i);
        end
        return n;
    endfunction

    logic                 start;
    logic [EW-1:0]        ux_e, uy_e;
    logic [SW-1:0]        ux_f, uy_f;
    logic                 x_ge_y, big_s;
    logic [EW-1:0]        big_e, small_e, diff;
    logic [SW:0]          big_f, small_f;
    logic [MW-1:0]        small_ext, shifted;
    logic [MW:0]          sum_d;
    logic [XW-1:0]        lz;
    logic [MW-1:0]        norm_m;
    logic signed [XW-1:0] norm_e, exp_r;
    logic                 round_up;
    logic [SW+1:0]        rnd;
    logic [SW-1:0]        frac;
    logic [W-1:0]         res_d;
    logic                 ovf_d, unf_d;

    always_comb begin
        start = beg_add_subt && (state_q == StIdle || state_q == StDone);
        ux_e  = Data_X[W-2:SW];
        uy_e  = Data_Y[W-2:SW];
        ux_f  = Data_X[SW-1:0];
        uy_f  = Data_Y[SW-1:0];

        // Alignment: the larger magnitude keeps its significand, the smaller is shifted down.
        x_ge_y    = {ex_q, fx_q} >= {ey_q, fy_q};
        big_s     = x_ge_y ? sx_q : sy_q;
        big_e     = x_ge_y ? ex_q : ey_q;
        small_e   = x_ge_y ? ey_q : ex_q;
        big_f     = x_ge_y ? fx_q : fy_q;
        small_f   = x_ge_y ? fy_q : fx_q;
        diff      = big_e - small_e;
        small_ext = {small_f, 3'b000};
        if (diff >= ShiftMax) begin
            shifted = {{(MW-1){1'b0}}, |small_f};
        end else begin
            shifted    = small_ext >> diff;
            shifted[0] = shifted[0] | (|(small_ext & ~({MW{1'b1}} << diff)));
        end

        sum_d = eff_sub_q ? ({1'b0, ma_q} - {1'b0, mb_q}) : ({1'b0, ma_q} + {1'b0, mb_q});

        lz = lzc(sum_q[MW-1:0]);
        if (sum_q[MW]) begin
            norm_m = {sum_q[MW:2], sum_q[1] | sum_q[0]};
            norm_e = exp_q + One;
        end else begin
            norm_m = sum_q[MW-1:0] << lz;
            norm_e = exp_q - $signed(lz);
        end

        round_up = ma_q[2] & (ma_q[1] | ma_q[0] | ma_q[3]);
        rnd      = {1'b0, ma_q[MW-1:3]} + {{(SW+1){1'b0}}, round_up};
        exp_r    = rnd[SW+1] ? exp_q + One : exp_q;
        frac     = rnd[SW+1] ? rnd[SW:1] : rnd[SW-1:0];

        ovf_d = 1'b0;
        unf_d = 1'b0;
        if (nx_q || ny_q || (ix_q && iy_q && (sx_q != sy_q))) begin
            res_d = QNan;
        end else if (ix_q || iy_q) begin
            res_d = {ix_q ? sx_q : sy_q, {EW{1'b1}}, {SW{1'b0}}};
        end else if (zero_q) begin
            // Only -0 + -0 keeps the negative sign; any other exact zero is +0.
            res_d = {sx_q & sy_q, {(W-1){1'b0}}};
        end else if (exp_r >= ExpMax) begin
            res_d = {sign_q, {EW{1'b1}}, {SW{1'b0}}};
            ovf_d = 1'b1;
        end else if (exp_r[XW-1] || exp_r == '0) begin
            res_d = {sign_q, {(W-1){1'b0}}};
            unf_d = 1'b1;
        end else begin
            res_d = {sign_q, exp_r[EW-1:0], frac};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= StIdle;
            ready_add_subt  <= 1'b0;
            add_subt_result <= '0;
            overflow_flag   <= 1'b0;
            underflow_flag  <= 1'b0;
            sx_q            <= 1'b0;
            sy_q            <= 1'b0;
            ix_q            <= 1'b0;
            iy_q            <= 1'b0;
            nx_q            <= 1'b0;
            ny_q            <= 1'b0;
            ex_q            <= '0;
            ey_q            <= '0;
            fx_q            <= '0;
            fy_q            <= '0;
            sign_q          <= 1'b0;
            eff_sub_q       <= 1'b0;
            zero_q          <= 1'b0;
            exp_q           <= '0;
            ma_q            <= '0;
            mb_q            <= '0;
            sum_q           <= '0;
        end else begin
            if (start) begin
                sx_q           <= Data_X[W-1];
                sy_q           <= Data_Y[W-1] ^ add_subt;
                ex_q           <= ux_e;
                ey_q           <= uy_e;
                fx_q           <= (ux_e != '0) ? {1'b1, ux_f} : '0;
                fy_q           <= (uy_e != '0) ? {1'b1, uy_f} : '0;
                ix_q           <= (ux_e == '1) && (ux_f == '0);
                iy_q           <= (uy_e == '1) && (uy_f == '0);
                nx_q           <= (ux_e == '1) && (ux_f != '0);
                ny_q           <= (uy_e == '1) && (uy_f != '0);
                ready_add_subt <= 1'b0;
                state_q        <= StAlign;
            end else begin
                unique case (state_q)
                    StIdle: ;
                    StAlign: begin
                        sign_q    <= big_s;
                        exp_q     <= $signed({2'b00, big_e});
                        ma_q      <= {big_f, 3'b000};
                        mb_q      <= shifted;
                        eff_sub_q <= sx_q ^ sy_q;
                        state_q   <= StAdd;
                    end
                    StAdd: begin
                        sum_q   <= sum_d;
                        state_q <= StNorm;
                    end
                    StNorm: begin
                        ma_q    <= norm_m;
                        exp_q   <= norm_e;
                        zero_q  <= (sum_q == '0);
                        state_q <= StRound;
                    end
                    StRound: begin
                        add_subt_result <= res_d;
                        overflow_flag   <= ovf_d;
                        underflow_flag  <= unf_d;
                        ready_add_subt  <= 1'b1;
                        state_q         <= StDone;
                    end
                    StDone: begin
                        if (ack_add_subt) begin
                            ready_add_subt <= 1'b0;
                            state_q        <= StIdle;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fp_add_subt_unit.sv
// Bench for fp_add_subt_unit: directed vector table, handshake corner sequences, and random
// operands checked against an exact-arithmetic reference model.
module tb_fp_add_subt_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        beg_add_subt = 1'b0;
    logic        ack_add_subt = 1'b0;
    logic        add_subt = 1'b0;
    logic [31:0] Data_X = '0;
    logic [31:0] Data_Y = '0;
    logic        ready_add_subt;
    logic [31:0] add_subt_result;
    logic        overflow_flag;
    logic        underflow_flag;

    int checks = 0;
    int errors = 0;

    fp_add_subt_unit dut (
        .clk            (clk),
        .reset          (reset),
        .beg_add_subt   (beg_add_subt),
        .ack_add_subt   (ack_add_subt),
        .add_subt       (add_subt),
        .Data_X         (Data_X),
        .Data_Y         (Data_Y),
        .ready_add_subt (ready_add_subt),
        .add_subt_result(add_subt_result),
        .overflow_flag  (overflow_flag),
        .underflow_flag (underflow_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic        op;
        logic [31:0] res;
        logic        ovf;
        logic        unf;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Exact value = signed integer magnitude in units of 2^-149, then RNE to 24 bits.
    function automatic void ref_model(input logic [31:0] x, input logic [31:0] y, input logic op,
                                      output logic [31:0] res, output logic ovf,
                                      output logic unf);
        logic          sx, sy, sr;
        logic [7:0]    ex, ey;
        logic [22:0]   fx, fy;
        logic [319:0]  ax, ay, mag, mant, rem, half;
        int            p, sh, e_r;
        ovf = 1'b0;
        unf = 1'b0;
        sx = x[31];
        sy = y[31] ^ op;
        ex = x[30:23];
        ey = y[30:23];
        fx = x[22:0];
        fy = y[22:0];
        if ((ex == 8'hFF && fx != 0) || (ey == 8'hFF && fy != 0) ||
            (ex == 8'hFF && ey == 8'hFF && sx != sy)) begin
            res = 32'h7FC00000;
        end else if (ex == 8'hFF) begin
            res = {sx, 8'hFF, 23'h0};
        end else if (ey == 8'hFF) begin
            res = {sy, 8'hFF, 23'h0};
        end else begin
            ax = (ex == 0) ? '0 : (320'({1'b1, fx}) << (ex - 1));
            ay = (ey == 0) ? '0 : (320'({1'b1, fy}) << (ey - 1));
            if (sx == sy) begin
                mag = ax + ay;
                sr  = sx;
            end else if (ax >= ay) begin
                mag = ax - ay;
                sr  = sx;
            end else begin
                mag = ay - ax;
                sr  = sy;
            end
            if (mag == 0) begin
                res = {sx & sy, 31'h0};
            end else begin
                p = 0;
                for (int i = 0; i < 320; i++) if (mag[i]) p = i;
                e_r  = p - 22;
                mant = mag;
                if (p >= 23) begin
                    sh   = p - 23;
                    mant = mag >> sh;
                    if (sh > 0) begin
                        rem  = mag & ((320'd1 << sh) - 1);
                        half = 320'd1 << (sh - 1);
                        if (rem > half || (rem == half && mant[0])) mant = mant + 1;
                    end
                    if (mant[24]) begin
                        mant = mant >> 1;
                        e_r++;
                    end
                end
                if (e_r >= 255) begin
                    res = {sr, 8'hFF, 23'h0};
                    ovf = 1'b1;
                end else if (e_r <= 0) begin
                    res = {sr, 31'h0};
                    unf = 1'b1;
                end else begin
                    res = {sr, e_r[7:0], mant[22:0]};
                end
            end
        end
    endfunction

    task automatic start_op(input logic [31:0] x, input logic [31:0] y, input logic o);
        @(negedge clk);
        Data_X = x;
        Data_Y = y;
        add_subt = o;
        beg_add_subt = 1'b1;
        @(negedge clk);
        beg_add_subt = 1'b0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!ready_add_subt && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic release_op();
        @(negedge clk);
        ack_add_subt = 1'b1;
        @(negedge clk);
        ack_add_subt = 1'b0;
    endtask

    function automatic logic [31:0] rand_near(input logic [31:0] x);
        logic [31:0] y;
        int          e;
        y = $urandom;
        e = int'(x[30:23]) + int'($urandom_range(0, 60)) - 30;
        if (e < 1) e = 1;
        if (e > 254) e = 254;
        y[30:23] = e[7:0];
        return y;
    endfunction

    initial begin
        int          n;
        int          r;
        logic [31:0] x, y, exp_res;
        logic        o, exp_ovf, exp_unf;

        repeat (3) @(negedge clk);
        check("reset ready", 32'(ready_add_subt), 32'h0);
        check("reset result", add_subt_result, 32'h0);
        check("reset ovf", 32'(overflow_flag), 32'h0);
        check("reset unf", 32'(underflow_flag), 32'h0);
        reset = 1'b1;

        vecs[0] = '{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 1'b0, 1'b0};
        vecs[1] = '{32'h40400000, 32'h40A00000, 1'b1, 32'hC0000000, 1'b0, 1'b0};
        vecs[2] = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 1'b0, 1'b0};
        vecs[3] = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 1'b0, 1'b0};
        vecs[4] = '{32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 1'b0, 1'b0};
        vecs[5] = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1, 1'b0};
        vecs[6] = '{32'h00800000, 32'h00800001, 1'b1, 32'h80000000, 1'b0, 1'b1};
        vecs[7] = '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 1'b0, 1'b0};
        vecs[8] = '{32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 1'b0, 1'b0};

        for (int i = 0; i < 9; i++) begin
            start_op(vecs[i].x, vecs[i].y, vecs[i].op);
            wait_ready(n);
            check($sformatf("vec%0d latency", i), 32'(n), 32'd4);
            check($sformatf("vec%0d result", i), add_subt_result, vecs[i].res);
            check($sformatf("vec%0d ovf", i), 32'(overflow_flag), 32'(vecs[i].ovf));
            check($sformatf("vec%0d unf", i), 32'(underflow_flag), 32'(vecs[i].unf));
            if (i == 0) begin
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    check($sformatf("ready held %0d", k), 32'(ready_add_subt), 32'h1);
                end
            end
            release_op();
            check($sformatf("vec%0d ready drop", i), 32'(ready_add_subt), 32'h0);
        end

        // beg while in ADD must be ignored
        start_op(32'h3F800000, 32'h40000000, 1'b0);
        @(negedge clk);
        Data_X = 32'h40400000;
        Data_Y = 32'h40A00000;
        add_subt = 1'b1;
        beg_add_subt = 1'b1;
        @(negedge clk);
        beg_add_subt = 1'b0;
        wait_ready(n);
        check("ignored beg latency", 32'(n), 32'd2);
        check("ignored beg result", add_subt_result, 32'h40400000);
        release_op();
        repeat (6) @(negedge clk);
        check("ignored beg no ready", 32'(ready_add_subt), 32'h0);

        // reset while in NORM aborts the operation
        start_op(32'h40400000, 32'h40A00000, 1'b1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort ready", 32'(ready_add_subt), 32'h0);
        check("abort result", add_subt_result, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        repeat (8) @(negedge clk);
        check("abort no ready", 32'(ready_add_subt), 32'h0);
        check("abort result held", add_subt_result, 32'h0);

        // beg and ack together in DONE starts a new operation
        start_op(32'h3F800000, 32'h40000000, 1'b0);
        wait_ready(n);
        check("beg+ack first", add_subt_result, 32'h40400000);
        @(negedge clk);
        Data_X = 32'h40400000;
        Data_Y = 32'h40A00000;
        add_subt = 1'b1;
        beg_add_subt = 1'b1;
        ack_add_subt = 1'b1;
        @(negedge clk);
        beg_add_subt = 1'b0;
        ack_add_subt = 1'b0;
        check("beg+ack ready drop", 32'(ready_add_subt), 32'h0);
        wait_ready(n);
        check("beg+ack latency", 32'(n), 32'd4);
        check("beg+ack second", add_subt_result, 32'hC0000000);
        release_op();

        for (int i = 0; i < 300; i++) begin
            x = $urandom;
            y = $urandom;
            o = 1'($urandom_range(0, 1));
            r = int'($urandom_range(0, 19));
            if (r < 12) y = rand_near(x);
            else if (r == 12) y = x;
            else if (r == 13) y[30:23] = 8'h00;
            else if (r == 14) x = {x[31], 8'hFF, 23'h0};
            else if (r == 15) y = {y[31], 8'hFF, 23'h0};
            else if (r == 16) begin
                x[30:23] = 8'hFE;
                y[30:23] = 8'hFE;
            end else if (r == 17) begin
                x[30:23] = 8'h01;
                y[30:23] = 8'h01;
            end
            ref_model(x, y, o, exp_res, exp_ovf, exp_unf);
            start_op(x, y, o);
            wait_ready(n);
            check($sformatf("rand%0d %h %s %h", i, x, o ? "-" : "+", y), add_subt_result,
                  exp_res);
            check($sformatf("rand%0d ovf", i), 32'(overflow_flag), 32'(exp_ovf));
            check($sformatf("rand%0d unf", i), 32'(underflow_flag), 32'(exp_unf));
            release_op();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
